// File: rtl/alu8.sv
// alu8: registered 8-bit ALU (ADD, SUB, AND, OR) with zero/negative/carry/overflow flags.
// Operands are decoded combinationally and captured on the rising clock edge when in_valid
// is high. out_valid pulses for one cycle per captured operation.
module alu8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    // Signed overflow on addition: operands share a sign that the result does not.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Signed overflow on subtraction: operands differ in sign and the result
    // takes the sign of the subtrahend.
    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] op_res;
    logic             op_carry;
    logic             op_ovf;

    logic [WIDTH-1:0] result_d,    result_q;
    logic             zero_d,      zero_q;
    logic             negative_d,  negative_q;
    logic             carry_d,     carry_q;
    logic             overflow_d,  overflow_q;
    logic             out_valid_d, out_valid_q;

    // Decode the selected operation into a result and its carry/overflow bits.
    always_comb begin
        add_sum  = {1'b0, a} + {1'b0, b};
        // Subtraction as a + ~b + 1 so bit WIDTH is the no-borrow carry.
        sub_sum  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        op_res   = '0;
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        case (op_e'(ctrl))
            OP_ADD: begin
                op_res   = add_sum[WIDTH-1:0];
                op_carry = add_sum[WIDTH];
                op_ovf   = add_ovf(a, b, add_sum[WIDTH-1:0]);
            end
            OP_SUB: begin
                op_res   = sub_sum[WIDTH-1:0];
                op_carry = sub_sum[WIDTH];
                op_ovf   = sub_ovf(a, b, sub_sum[WIDTH-1:0]);
            end
            OP_AND: op_res = a & b;
            OP_OR:  op_res = a | b;
            default: op_res = '0;
        endcase
    end

    // Next-state: load on in_valid, otherwise hold; out_valid follows in_valid.
    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            result_d   = op_res;
            zero_d     = (op_res == '0);
            negative_d = op_res[WIDTH-1];
            carry_d    = op_carry;
            overflow_d = op_ovf;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu8.sv
// tb_alu8: scoreboard bench for alu8. Stimulus pushes hand-computed expectations
// ({result, zero, negative, carry, overflow}) into a queue; a monitor pops and
// compares on every falling edge where out_valid is high.
module tb_alu8;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] ctrl;
    logic [7:0] result;
    logic       zero;
    logic       negative;
    logic       carry;
    logic       overflow;
    logic       out_valid;

    typedef struct packed {
        logic [7:0] res;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    alu8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .ctrl      (ctrl),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic z, input logic n,
                                input logic c, input logic v);
        exp_t e;
        e.res = r; e.z = z; e.n = n; e.c = c; e.v = v;
        return e;
    endfunction

    function automatic logic [11:0] outs();
        return {result, zero, negative, carry, overflow};
    endfunction

    // Drive one valid operation just after a rising edge and record its expectation.
    task automatic issue(input logic [1:0] op, input logic [7:0] xa, input logic [7:0] xb,
                         input exp_t e);
        @(posedge clk); #1;
        in_valid = 1'b1; ctrl = op; a = xa; b = xb;
        exp_q.push_back(e);
        last_exp = e;
    endtask

    // Monitor: compare every presented output against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 12'(out_valid), 12'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("scoreboard", {result, zero, negative, carry, overflow},
                          {e.res, e.z, e.n, e.c, e.v});
                end
            end
        end
    end

    initial begin
        // Reset with active-looking inputs; outputs must already be clear before any edge.
        rst_n = 1'b0; in_valid = 1'b1; a = 8'h55; b = 8'hAA; ctrl = 2'b00;
        #3;
        check("reset_outputs", {result, zero, negative, carry, overflow}, 12'h000);
        check("reset_out_valid", 12'(out_valid), 12'(0));
        @(posedge clk); #1;
        check("reset_held_edge", {outs(), out_valid}, 13'h0000 >> 1);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // Back-to-back directed operations.
        issue(2'b00, 8'h00, 8'h24, mk(8'h24, 0, 0, 0, 0));
        issue(2'b00, 8'hFF, 8'h01, mk(8'h00, 1, 0, 1, 0));
        issue(2'b00, 8'h7F, 8'h01, mk(8'h80, 0, 1, 0, 1));
        issue(2'b01, 8'h04, 8'h24, mk(8'hE0, 0, 1, 0, 0));
        issue(2'b01, 8'h24, 8'h24, mk(8'h00, 1, 0, 1, 0));
        issue(2'b01, 8'h80, 8'h01, mk(8'h7F, 0, 0, 1, 1));
        issue(2'b11, 8'h00, 8'h24, mk(8'h24, 0, 0, 0, 0));
        issue(2'b10, 8'hF0, 8'h0F, mk(8'h00, 1, 0, 0, 0));
        issue(2'b00, 8'h10, 8'h20, mk(8'h30, 0, 0, 0, 0));

        // Hold: new operands with in_valid low must not disturb the registers.
        @(posedge clk); #1;
        in_valid = 1'b0; ctrl = 2'b10; a = 8'hFF; b = 8'hFF;
        @(posedge clk); #1;
        check("hold_out_valid", 12'(out_valid), 12'(0));
        check("hold_outputs", outs(), {last_exp.res, last_exp.z, last_exp.n, last_exp.c, last_exp.v});
        @(posedge clk); #1;
        check("hold_outputs_2", outs(), {last_exp.res, last_exp.z, last_exp.n, last_exp.c, last_exp.v});

        // Capture a nonzero result, then reset between edges with a pending valid op.
        issue(2'b00, 8'h7F, 8'h01, mk(8'h80, 0, 1, 0, 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); #1;
        in_valid = 1'b1; ctrl = 2'b11; a = 8'h5A; b = 8'hA5;
        #1 rst_n = 1'b0;
        #1;
        check("midreset_outputs", outs(), 12'h000);
        check("midreset_out_valid", 12'(out_valid), 12'(0));
        @(posedge clk); #1;
        check("midreset_discard", {outs(), out_valid}, 13'h0000 >> 1);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // First operation after release.
        issue(2'b01, 8'h24, 8'h04, mk(8'h20, 0, 0, 1, 0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_reset_result", outs(), 12'h200 | 12'h002);
        check("post_reset_out_valid", 12'(out_valid), 12'(1));

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", 12'(exp_q.size()), 12'(0));
        repeat (2) @(posedge clk);
        stim_done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #20000;
        if (!stim_done) begin
            $display("FAIL timeout: stimulus did not complete");
            $fatal(1, "timeout");
        end
    end

endmodule

// File: doc/alu8.md
Name: alu8

Overview:
- 8-bit registered arithmetic/logic unit for the datapath.
- Performs one of four operations on two 8-bit operands, selected by a 2-bit control code.
- Captures the result and status flags in output registers on the clock edge when an input-valid strobe is present.
- Sits between the register-file read ports and the writeback stage.

Parameters:
- WIDTH, 8, operand and result width in bits. All values in this spec assume 8.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and ctrl are valid this cycle; capture on the rising edge.
- a  input  8  operand A.
- b  input  8  operand B.
- ctrl  input  2  operation select.
- result  output  8  registered operation result.
- zero  output  1  registered flag; 1 when the captured result is 0x00.
- negative  output  1  registered flag; copy of result[7].
- carry  output  1  registered carry / no-borrow flag.
- overflow  output  1  registered signed-overflow flag.
- out_valid  output  1  1 for exactly one cycle after each captured operation.

Behaviour:
- Reset:
  - While rst_n = 0, regardless of clk: result = 0x00; zero, negative, carry, overflow = 0; out_valid = 0.
  - Deassertion takes effect at the next rising edge.
- Operation decode (combinational, from a, b, ctrl):
  - 00 ADD: {c, r} = a + b. carry = c. overflow = 1 when a[7] == b[7] and r[7] != a[7].
  - 01 SUB: r = a - b, computed as a + ~b + 1. carry = bit 8 of that sum, i.e. 1 when a >= b unsigned (no borrow). overflow = 1 when a[7] != b[7] and r[7] != a[7].
  - 10 AND: r = a & b. carry = 0, overflow = 0.
  - 11 OR: r = a | b. carry = 0, overflow = 0.
- All arithmetic is modulo 256; results wrap.
- zero and negative are derived from r for every operation.
- Latency: one cycle. On a rising edge with in_valid = 1, result and all flags load the decoded values and out_valid goes to 1 on the same edge.
- Hold: on a rising edge with in_valid = 0, result and all flags hold their previous values and out_valid goes to 0.
- Back-to-back: in_valid may stay high on consecutive cycles; each edge captures a new operation and out_valid stays high.
- Reset asserted mid-operation: outputs clear immediately and the pending capture is discarded.
- No X propagation: every ctrl code is defined, so no illegal state exists.

Test Plan:
- Reset: rst_n = 0 with nonzero inputs and in_valid = 1 -> result = 0x00, all flags 0, out_valid = 0, without waiting for a clock edge.
- ADD: a = 0x00, b = 0x24, ctrl = 00, in_valid = 1 -> next edge result = 0x24, zero = 0, negative = 0, carry = 0, overflow = 0, out_valid = 1. Wrap cases:
  - 0xFF + 0x01 -> result = 0x00, zero = 1, carry = 1, overflow = 0.
  - 0x7F + 0x01 -> result = 0x80, negative = 1, overflow = 1.
- SUB: a = 0x04, b = 0x24, ctrl = 01 -> result = 0xE0, carry = 0 (borrow), negative = 1, overflow = 0. Further cases:
  - 0x24 - 0x24 -> result = 0x00, zero = 1, carry = 1.
  - 0x80 - 0x01 -> result = 0x7F, overflow = 1.
- Logic ops:
  - a = 0x00, b = 0x24, ctrl = 11 (OR) -> result = 0x24, carry = 0, overflow = 0.
  - a = 0xF0, b = 0x0F, ctrl = 10 (AND) -> result = 0x00, zero = 1.
- Hold and valid:
  - After a captured op, drive new a/b/ctrl with in_valid = 0 -> result and flags unchanged, out_valid = 0 on the next edge.
  - Three consecutive valid cycles -> three successive results, out_valid held at 1.
- Reset mid-stream: assert rst_n = 0 between edges while in_valid = 1 -> outputs clear asynchronously. After release, the first valid op produces the correct result one cycle later.
